calc_engine: RTL and testbench
==============================

Name: calc_engine

Overview:
- Parametrised successor to the board calculator datapath.
- Folds the key-driven control unit, operand registers and arithmetic unit into one sequential engine of generic width.
- Accepts decoded keypad strobes and builds signed decimal operands. Performs add/sub, and optionally a multi-cycle multiply.
- Supports chained and repeated "=" operation, and reports a registered result with overflow/zero flags to the seven-segment output unit.

Parameters:
WIDTH, 8, two's-complement operand/result width (min 4)
MAX_DIGITS, 3, maximum decimal digits accepted per operand entry

Ports:
i_CLOCK  in  1  system clock
i_RESET  in  1  asynchronous active-high reset
i_CLEAR_ALL  in  1  synchronous clear; same effect as reset, sampled each edge
i_KEY_VALID  in  1  one-cycle strobe; i_KEY valid this cycle
i_KEY  in  4  0-9 digit, A add, B sub, C mul, D negate, E equals, F clear entry
o_DISPLAY  out  WIDTH  signed value to display (current entry or result)
o_STAGE  out  2  0 = entering A, 1 = entering B, 2 = result, 3 = busy
o_OP  out  2  pending operator: 0 add, 1 sub, 2 mul
o_DIGITS  out  clog2(MAX_DIGITS+1)  digits entered in current operand
o_OVERFLOW  out  1  last result not representable in WIDTH bits
o_ZERO  out  1  o_DISPLAY == 0

Behaviour:
- Reset/clear-all:
  - A = B = result = 0, o_STAGE = 0, o_OP = 0, o_DIGITS = 0, o_OVERFLOW = 0, o_ZERO = 1.
  - This takes priority over any key in the same cycle. Reset mid-multiply aborts it.
- Keys are acted on only in the cycle i_KEY_VALID = 1. All outputs are registered, so the effect is visible one cycle after the strobe.
- Digit entry:
  - New magnitude = mag*10 + d, sign preserved.
  - The digit is ignored if o_DIGITS == MAX_DIGITS, or if the new magnitude exceeds 2^(WIDTH-1)-1.
  - A leading 0 does not increment o_DIGITS.
- State A (stage 0):
  - Digit: entry into A.
  - D: negates A.
  - F: A = 0, digits = 0.
  - A/B/C: latch op, go to B with B = 0 and digits = 0.
  - E: result = A, go to R.
- State B (stage 1):
  - Digit, D and F act on B.
  - Op key: replaces the pending op only.
  - E: compute A op B. Add/sub go to R next cycle; mul goes to BUSY.
- State R (stage 2):
  - Digit: A = digit, go to A.
  - Op key: A = result, B = 0, go to B (chaining).
  - E: A = result, recompute with the retained B and op (repeat-equals).
  - D: A = -result, go to A.
  - F: all cleared, go to A.
- State BUSY (stage 3, mul only):
  - Lasts exactly WIDTH cycles after the E strobe; all keys are ignored.
  - Then go to R.
- o_DISPLAY shows A in state A, B in state B, result in R, and the held previous display in BUSY.
- Arithmetic:
  - Result is the low WIDTH bits of the exact result (wraps).
  - o_OVERFLOW is set when the exact result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Negating -2^(WIDTH-1) yields the same value with o_OVERFLOW = 1.
  - o_OVERFLOW is cleared on the next accepted key other than E.
- C (mul) with CALC_MUL_EN undefined: ignored in every state; o_OP never equals 2.

Optional Feature:
- Macro: CALC_MUL_EN.
- Defined:
  - C selects multiply.
  - Signed shift-add multiply over WIDTH cycles with a 2*WIDTH-bit internal product.
  - Overflow is set if the product's upper WIDTH+1 bits are not all equal.
- Undefined:
  - No multiplier hardware.
  - BUSY state unreachable.
  - C key is a no-op.

Decomposition:
- Package calc_pkg holds:
  - key code constants (KEY_ADD = 4'hA … KEY_CE = 4'hF)
  - stage encodings (STG_A, STG_B, STG_R, STG_BUSY)
  - op encodings (OP_ADD, OP_SUB, OP_MUL)
- Sub-module calc_seq_mul: start/done handshake, WIDTH-parameterised sequential signed multiplier. Instantiated only under CALC_MUL_EN.

Test Plan (WIDTH = 8, MAX_DIGITS = 3):
- Keys 1,2 then i_RESET pulse mid-entry -> o_DISPLAY 0, o_STAGE 0, o_ZERO 1.
- Keys 1,2,A,5,E -> o_DISPLAY 17, o_STAGE 2, o_OVERFLOW 0, one cycle after the E strobe.
- Keys 1,2,0,A,1,0,E -> o_DISPLAY -126 (8'h82), o_OVERFLOW 1. Next key 3 -> o_OVERFLOW 0, o_DISPLAY 3.
- Entry limits:
  - Keys 1,2,8 -> o_DISPLAY 12, o_DIGITS 2 (128 rejected).
  - F, then 9,9,9 -> 99 (999 rejected).
- Chaining: keys 5,B,7,E -> -2; E -> -9; A,3,E -> -6. Then D -> o_STAGE 0, o_DISPLAY 6.
- CALC_MUL_EN:
  - 1,2,C,5,E -> o_STAGE 3 for 8 cycles, a digit key during BUSY ignored, then 60.
  - 2,0,C,7,E -> 140 wraps to -116, o_OVERFLOW 1.
  - Without the macro, C ignored: 2,C,3,E -> o_OP 0, o_STAGE 0, o_DISPLAY 23 immediately after the 3 strobe; on E, o_STAGE 2, o_DISPLAY 23.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, stage and operator encodings for the calculator engine.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_NEG = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CE  = 4'hF;

  typedef enum logic [1:0] {
    STG_A    = 2'd0,
    STG_B    = 2'd1,
    STG_R    = 2'd2,
    STG_BUSY = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

endpackage

// File: rtl/calc_if.sv
// Keypad strobe inputs and registered display/status outputs of the calculator engine.
// The master drives keys and clear; the slave (engine) drives the display side.
interface calc_if #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
);
  logic                              i_CLEAR_ALL;
  logic                              i_KEY_VALID;
  logic [3:0]                        i_KEY;
  logic [WIDTH-1:0]                  o_DISPLAY;
  logic [1:0]                        o_STAGE;
  logic [1:0]                        o_OP;
  logic [$clog2(MAX_DIGITS+1)-1:0]   o_DIGITS;
  logic                              o_OVERFLOW;
  logic                              o_ZERO;

  modport master (
    output i_CLEAR_ALL, i_KEY_VALID, i_KEY,
    input  o_DISPLAY, o_STAGE, o_OP, o_DIGITS, o_OVERFLOW, o_ZERO
  );

  modport slave (
    input  i_CLEAR_ALL, i_KEY_VALID, i_KEY,
    output o_DISPLAY, o_STAGE, o_OP, o_DIGITS, o_OVERFLOW, o_ZERO
  );
endinterface

// File: rtl/calc_seq_mul.sv
// Sequential signed shift-add multiplier: operands latched on start_i, done_o on the
// WIDTH-th cycle after start with prod_o valid combinationally; abort_i cancels.
module calc_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 abort_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               last;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_step;

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign addend = mplier_q[0] ? mcand_q : '0;
  // The multiplier's sign bit carries negative weight in two's complement.
  assign acc_step = last ? (acc_q - addend) : (acc_q + addend);

  assign done_o = busy_q && last;
  assign prod_o = acc_step;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{a_i[WIDTH-1]}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Keypad-driven signed calculator engine; all outputs registered one cycle after a key strobe.
// Multiply (C key, BUSY stage) is built only when CALC_MUL_EN is defined.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic  i_CLOCK,
  input  logic  i_RESET,
  calc_if.slave bus
);

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  stage_e           stage_q, stage_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             zero_q;

  logic [3:0] key;
  logic       key_act, is_digit, is_op, is_neg, is_eq, is_ce;
  op_e        key_op;

  assign key      = bus.i_KEY;
  assign key_act  = bus.i_KEY_VALID && !(key == KEY_MUL && !MUL_EN);
  assign is_digit = (key < 4'd10);
  assign is_op    = (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL && MUL_EN);
  assign is_neg   = (key == KEY_NEG);
  assign is_eq    = (key == KEY_EQ);
  assign is_ce    = (key == KEY_CE);

  always_comb begin
    key_op = OP_ADD;
    if (key == KEY_SUB) key_op = OP_SUB;
    else if (key == KEY_MUL) key_op = OP_MUL;
  end

  // Digit entry works on magnitude so the sign survives appending digits.
  logic [WIDTH-1:0]   ent, ent_mag, ent_new, ent_neg;
  logic [WIDTH+3:0]   ent_new_mag;
  logic               dig_ok, dig_inc, neg_ovf;

  assign ent         = (stage_q == STG_A) ? a_q : b_q;
  assign ent_mag     = ent[WIDTH-1] ? (-ent) : ent;
  assign ent_new_mag = ({4'b0, ent_mag} << 3) + ({4'b0, ent_mag} << 1) + (WIDTH+4)'(key);
  assign dig_ok      = (digits_q != DW'(MAX_DIGITS)) && (ent_new_mag <= {4'b0, MAXPOS});
  assign dig_inc     = !(ent_mag == '0 && key == 4'd0);
  assign ent_new     = ent[WIDTH-1] ? (-ent_new_mag[WIDTH-1:0]) : ent_new_mag[WIDTH-1:0];
  assign ent_neg     = -ent;
  assign neg_ovf     = (ent == MINNEG);

  // Left operand is A on first evaluation, the previous result on repeat-equals.
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  assign alu_x   = (stage_q == STG_R) ? res_q : a_q;
  assign sum     = (op_q == OP_SUB) ? ({alu_x[WIDTH-1], alu_x} - {b_q[WIDTH-1], b_q})
                                    : ({alu_x[WIDTH-1], alu_x} + {b_q[WIDTH-1], b_q});
  assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];

`ifdef CALC_MUL_EN
  logic               mul_start, mul_done, mul_ovf;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     mul_hi;

  assign mul_start = key_act && !bus.i_CLEAR_ALL && is_eq && (op_q == OP_MUL) &&
                     (stage_q == STG_B || stage_q == STG_R);
  assign mul_hi    = mul_prod[2*WIDTH-1:WIDTH-1];
  assign mul_ovf   = !((&mul_hi) || (~|mul_hi));

  calc_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (i_CLOCK),
    .rst_i   (i_RESET),
    .abort_i (bus.i_CLEAR_ALL),
    .start_i (mul_start),
    .a_i     (alu_x),
    .b_i     (b_q),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`endif

  logic             ent_wr;
  logic [WIDTH-1:0] ent_d;

  always_comb begin
    stage_d  = stage_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    ent_wr   = 1'b0;
    ent_d    = ent;
    if (bus.i_CLEAR_ALL) begin
      stage_d  = STG_A;
      op_d     = OP_ADD;
      a_d      = '0;
      b_d      = '0;
      res_d    = '0;
      digits_d = '0;
      ovf_d    = 1'b0;
    end else if (stage_q == STG_BUSY) begin
`ifdef CALC_MUL_EN
      if (mul_done) begin
        stage_d = STG_R;
        res_d   = mul_prod[WIDTH-1:0];
        ovf_d   = mul_ovf;
      end
`else
      stage_d = STG_R;
`endif
    end else if (key_act) begin
      if (!is_eq) ovf_d = 1'b0;
      if (stage_q == STG_R) begin
        if (is_digit) begin
          a_d      = WIDTH'(key);
          digits_d = (key != 4'd0) ? DW'(1) : '0;
          stage_d  = STG_A;
        end else if (is_op) begin
          a_d      = res_q;
          b_d      = '0;
          digits_d = '0;
          op_d     = key_op;
          stage_d  = STG_B;
        end else if (is_neg) begin
          a_d      = -res_q;
          ovf_d    = (res_q == MINNEG);
          digits_d = '0;
          stage_d  = STG_A;
        end else if (is_ce) begin
          a_d      = '0;
          b_d      = '0;
          res_d    = '0;
          op_d     = OP_ADD;
          digits_d = '0;
          stage_d  = STG_A;
        end else if (is_eq) begin
          a_d = res_q;
          if (op_q == OP_MUL) begin
            stage_d = STG_BUSY;
          end else begin
            res_d = sum[WIDTH-1:0];
            ovf_d = sum_ovf;
          end
        end
      end else begin
        if (is_digit) begin
          if (dig_ok) begin
            ent_wr = 1'b1;
            ent_d  = ent_new;
            if (dig_inc) digits_d = digits_q + DW'(1);
          end
        end else if (is_neg) begin
          ent_wr = 1'b1;
          ent_d  = ent_neg;
          ovf_d  = neg_ovf;
        end else if (is_ce) begin
          ent_wr   = 1'b1;
          ent_d    = '0;
          digits_d = '0;
        end else if (is_op) begin
          op_d = key_op;
          if (stage_q == STG_A) begin
            b_d      = '0;
            digits_d = '0;
            stage_d  = STG_B;
          end
        end else if (is_eq) begin
          if (stage_q == STG_A) begin
            res_d   = a_q;
            stage_d = STG_R;
          end else if (op_q == OP_MUL) begin
            stage_d = STG_BUSY;
          end else begin
            res_d   = sum[WIDTH-1:0];
            ovf_d   = sum_ovf;
            stage_d = STG_R;
          end
        end
        if (ent_wr) begin
          if (stage_q == STG_A) a_d = ent_d;
          else                  b_d = ent_d;
        end
      end
    end
  end

  always_comb begin
    case (stage_d)
      STG_A:   disp_d = a_d;
      STG_B:   disp_d = b_d;
      STG_R:   disp_d = res_d;
      default: disp_d = disp_q;
    endcase
  end

  always_ff @(posedge i_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      stage_q  <= STG_A;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      disp_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      stage_q  <= stage_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      disp_q   <= disp_d;
      zero_q   <= (disp_d == '0);
    end
  end

  assign bus.o_DISPLAY  = disp_q;
  assign bus.o_STAGE    = stage_q;
  assign bus.o_OP       = op_q;
  assign bus.o_DIGITS   = digits_q;
  assign bus.o_OVERFLOW = ovf_q;
  assign bus.o_ZERO     = zero_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed key-sequence bench for calc_engine (WIDTH 8, MAX_DIGITS 3); multiply
// vectors apply when CALC_MUL_EN is defined, otherwise the C-ignored vector runs.
module tb_calc_engine;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  calc_if #(.WIDTH(8), .MAX_DIGITS(3)) bus ();

  calc_engine #(.WIDTH(8), .MAX_DIGITS(3)) dut (
    .i_CLOCK (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.i_KEY_VALID = 1'b1;
    bus.i_KEY       = k;
    @(negedge clk);
    bus.i_KEY_VALID = 1'b0;
  endtask

  task automatic clear_all();
    @(negedge clk);
    bus.i_CLEAR_ALL = 1'b1;
    bus.i_KEY_VALID = 1'b1;
    bus.i_KEY       = 4'd5;
    @(negedge clk);
    bus.i_CLEAR_ALL = 1'b0;
    bus.i_KEY_VALID = 1'b0;
  endtask

  function automatic int disp();
    return int'($signed(bus.o_DISPLAY));
  endfunction

  initial begin
    bus.i_CLEAR_ALL = 1'b0;
    bus.i_KEY_VALID = 1'b0;
    bus.i_KEY       = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_disp",  disp(), 0);
    check_eq("rst_stage", int'(bus.o_STAGE), 0);
    check_eq("rst_op",    int'(bus.o_OP), 0);
    check_eq("rst_dig",   int'(bus.o_DIGITS), 0);
    check_eq("rst_ovf",   int'(bus.o_OVERFLOW), 0);
    check_eq("rst_zero",  int'(bus.o_ZERO), 1);

    // Reset pulse in the middle of an entry
    press(4'd1); press(4'd2);
    check_eq("entry12", disp(), 12);
    check_eq("entry12_zero", int'(bus.o_ZERO), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("midrst_disp",  disp(), 0);
    check_eq("midrst_stage", int'(bus.o_STAGE), 0);
    check_eq("midrst_zero",  int'(bus.o_ZERO), 1);
    check_eq("midrst_dig",   int'(bus.o_DIGITS), 0);

    // 12 + 5
    press(4'd1); press(4'd2); press(KEY_ADD); press(4'd5);
    check_eq("b_stage", int'(bus.o_STAGE), 1);
    check_eq("b_disp",  disp(), 5);
    press(KEY_EQ);
    check_eq("add_disp",  disp(), 17);
    check_eq("add_stage", int'(bus.o_STAGE), 2);
    check_eq("add_ovf",   int'(bus.o_OVERFLOW), 0);

    // Clear-all wins over a simultaneous digit key
    clear_all();
    check_eq("clr_disp",  disp(), 0);
    check_eq("clr_stage", int'(bus.o_STAGE), 0);

    // 120 + 10 overflows to -126
    press(4'd1); press(4'd2); press(4'd0);
    check_eq("dig3", int'(bus.o_DIGITS), 3);
    press(KEY_ADD); press(4'd1); press(4'd0); press(KEY_EQ);
    check_eq("ovf_disp", disp(), -126);
    check_eq("ovf_flag", int'(bus.o_OVERFLOW), 1);
    press(4'd3);
    check_eq("ovf_clr",      int'(bus.o_OVERFLOW), 0);
    check_eq("ovf_clr_disp", disp(), 3);
    check_eq("ovf_clr_stg",  int'(bus.o_STAGE), 0);

    // Entry limits
    clear_all();
    press(4'd1); press(4'd2); press(4'd8);
    check_eq("lim128_disp", disp(), 12);
    check_eq("lim128_dig",  int'(bus.o_DIGITS), 2);
    press(KEY_CE);
    check_eq("ce_disp", disp(), 0);
    check_eq("ce_dig",  int'(bus.o_DIGITS), 0);
    press(4'd9); press(4'd9); press(4'd9);
    check_eq("lim999_disp", disp(), 99);
    check_eq("lim999_dig",  int'(bus.o_DIGITS), 2);

    // Leading zeros, negate, sign kept while appending
    press(KEY_CE); press(4'd0); press(4'd0);
    check_eq("lead0_dig", int'(bus.o_DIGITS), 0);
    press(4'd5);
    check_eq("lead0_dig5", int'(bus.o_DIGITS), 1);
    press(KEY_NEG); press(4'd7);
    check_eq("neg_append", disp(), -57);

    // Chaining and repeat-equals
    clear_all();
    press(4'd5); press(KEY_SUB); press(4'd7); press(KEY_EQ);
    check_eq("sub_disp", disp(), -2);
    press(KEY_EQ);
    check_eq("rep_eq", disp(), -9);
    press(KEY_ADD);
    check_eq("chain_stage", int'(bus.o_STAGE), 1);
    check_eq("chain_b0",    disp(), 0);
    press(4'd3); press(KEY_EQ);
    check_eq("chain_disp", disp(), -6);
    press(KEY_NEG);
    check_eq("rneg_stage", int'(bus.o_STAGE), 0);
    check_eq("rneg_disp",  disp(), 6);

    // Negating the most negative value
    clear_all();
    press(4'd1); press(4'd2); press(4'd0); press(KEY_ADD); press(4'd8); press(KEY_EQ);
    check_eq("min_disp", disp(), -128);
    press(KEY_NEG);
    check_eq("negmin_disp", disp(), -128);
    check_eq("negmin_ovf",  int'(bus.o_OVERFLOW), 1);
    press(KEY_CE);
    check_eq("negmin_ce_ovf", int'(bus.o_OVERFLOW), 0);

`ifdef CALC_MUL_EN
    begin
      int n_busy;
      clear_all();
      press(4'd1); press(4'd2); press(KEY_MUL);
      check_eq("mul_op", int'(bus.o_OP), 2);
      press(4'd5); press(KEY_EQ);
      check_eq("busy_hold", disp(), 5);
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.o_STAGE != 2'd3) break;
        n_busy++;
        bus.i_KEY_VALID = (n_busy == 2);
        bus.i_KEY       = 4'd9;
        @(negedge clk);
      end
      bus.i_KEY_VALID = 1'b0;
      check_eq("busy_cycles", n_busy, 8);
      check_eq("mul_disp",  disp(), 60);
      check_eq("mul_stage", int'(bus.o_STAGE), 2);
      check_eq("mul_ovf",   int'(bus.o_OVERFLOW), 0);

      press(4'd2); press(4'd0); press(KEY_MUL); press(4'd7); press(KEY_EQ);
      for (int i = 0; i < 20; i++) begin
        if (bus.o_STAGE != 2'd3) break;
        @(negedge clk);
      end
      check_eq("mulw_stage", int'(bus.o_STAGE), 2);
      check_eq("mulw_disp",  disp(), -116);
      check_eq("mulw_ovf",   int'(bus.o_OVERFLOW), 1);
    end
`else
    clear_all();
    press(4'd2); press(KEY_MUL);
    check_eq("noc_op",    int'(bus.o_OP), 0);
    check_eq("noc_stage", int'(bus.o_STAGE), 0);
    press(4'd3);
    check_eq("noc_op3",    int'(bus.o_OP), 0);
    check_eq("noc_stage3", int'(bus.o_STAGE), 0);
    check_eq("noc_disp3",  disp(), 23);
    press(KEY_EQ);
    check_eq("noc_eq_stage", int'(bus.o_STAGE), 2);
    check_eq("noc_eq_disp",  disp(), 23);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
